// File: rtl/inst_queue_pkg.sv
// Shared constants for the instruction queue slice.
package inst_queue_pkg;
  localparam int   InstSize = 32;
  localparam int   IQDepth  = 16;
  localparam logic zero     = 1'b0;
  localparam logic one      = 1'b1;
endpackage

// File: rtl/iq_ram.sv
// Simple dual-port register array: synchronous write at tail, async read at head.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQDepth,
  parameter int W     = 2 * InstSize,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  // Storage is intentionally unreset; pointers decide what is meaningful.
  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// with a registered one-cycle valid pulse per pop and a mispredict flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH       = IQDepth,
  parameter int FULL_MARGIN = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                en_fetch,
  input  logic [InstSize-1:0] Inst_fetch,
  input  logic [InstSize-1:0] pc_fetch,
  output logic                IQ_isfull,
  input  logic                Get_Inst,
  output logic                en_out,
  output logic [InstSize-1:0] Inst_out,
  output logic [InstSize-1:0] pc_out,
  output logic                IQ_isempty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - FULL_MARGIN);

  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [2*InstSize-1:0] rd_data;
  logic                  push, pop, wr_en;

  // Eligibility uses the pre-update count, so a push at full is dropped
  // even when a pop frees a slot in the same cycle.
  assign push  = en_fetch && (count < DEPTH_C);
  assign pop   = Get_Inst && (count != '0);
  assign wr_en = push && rdy_in && !clear;

  iq_ram #(.DEPTH(DEPTH), .W(2*InstSize), .AW(PTR_W)) u_ram (
    .clk_in (clk_in),
    .we     (wr_en),
    .waddr  (tail),
    .wdata  ({pc_fetch, Inst_fetch}),
    .raddr  (head),
    .rdata  (rd_data)
  );

  // Pointer, count and output register update: reset > clear > stall > run.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      en_out   <= zero;
      Inst_out <= '0;
      pc_out   <= '0;
    end else if (clear) begin
      // Flush keeps the last presented data; only the valid drops.
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      en_out <= zero;
    end else if (rdy_in) begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head               <= head + 1'b1;
        {pc_out, Inst_out} <= rd_data;
        en_out             <= one;
      end else begin
        en_out <= zero;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign IQ_isempty = (count == '0);
  assign IQ_isfull  = (count >= FULL_TH);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, wrap, simultaneous
// push/pop, flush and stall scenarios with hand-computed expectations.
module tb_inst_queue;

  logic        clk_in, rst_in, rdy_in, clear, en_fetch, Get_Inst;
  logic [31:0] Inst_fetch, pc_fetch;
  logic        IQ_isfull, en_out, IQ_isempty;
  logic [31:0] Inst_out, pc_out;

  int errors = 0;
  int checks = 0;
  int m_count = 0;

  inst_queue #(.DEPTH(16), .FULL_MARGIN(1)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .en_fetch   (en_fetch),
    .Inst_fetch (Inst_fetch),
    .pc_fetch   (pc_fetch),
    .IQ_isfull  (IQ_isfull),
    .Get_Inst   (Get_Inst),
    .en_out     (en_out),
    .Inst_out   (Inst_out),
    .pc_out     (pc_out),
    .IQ_isempty (IQ_isempty)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Occupancy model of the fetch protocol; a push at full is a violation.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) m_count <= 0;
    else if (clear) m_count <= 0;
    else if (rdy_in) begin
      assert (!(en_fetch && m_count == 16))
        else $error("fetch pushed into a full queue");
      m_count <= m_count + ((en_fetch && m_count < 16) ? 1 : 0)
                         - ((Get_Inst && m_count != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_push(input logic en, input logic [31:0] pc);
    en_fetch   = en;
    pc_fetch   = pc;
    Inst_fetch = inst_of(pc);
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; Get_Inst = 1'b0;
    set_push(1'b0, 32'h0);
    #12;
    checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL rst_en_out got %b want 0", en_out); end
    checks++; if (pc_out !== 32'h0 || Inst_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", pc_out, Inst_out); end
    checks++; if (IQ_isempty !== 1'b1 || IQ_isfull !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b want 1/0", IQ_isempty, IQ_isfull); end
    rst_in = 1'b1;
    tick();
    // Traffic, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin set_push(1'b1, 32'h10 + 4*i); tick(); end
    set_push(1'b0, 32'h0);
    Get_Inst = 1'b1; tick(); Get_Inst = 1'b0;
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h10) begin errors++; $display("FAIL pre_rst_pop got en=%b pc=%h want 1/00000010", en_out, pc_out); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL async_rst got en=%b empty=%b want 0/1", en_out, IQ_isempty); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h want 0", pc_out); end
    rst_in = 1'b1;
    Get_Inst = 1'b1; tick(); Get_Inst = 1'b0;
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL pop_after_rst got en=%b empty=%b want 0/1", en_out, IQ_isempty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      set_push(1'b1, 32'(4*i));
      tick();
      checks++; if (IQ_isfull !== ((i + 1) >= 15)) begin errors++; $display("FAIL fill_full cnt=%0d got %b want %b", i+1, IQ_isfull, ((i+1) >= 15)); end
      checks++; if (IQ_isempty !== 1'b0) begin errors++; $display("FAIL fill_empty cnt=%0d got %b want 0", i+1, IQ_isempty); end
    end
    set_push(1'b0, 32'h0);
    Get_Inst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (en_out !== 1'b1 || pc_out !== 32'(4*i) || Inst_out !== inst_of(32'(4*i))) begin errors++; $display("FAIL drain_%0d got en=%b pc=%h inst=%h want 1/%h/%h", i, en_out, pc_out, Inst_out, 32'(4*i), inst_of(32'(4*i))); end
    end
    checks++; if (IQ_isempty !== 1'b1 || IQ_isfull !== 1'b0) begin errors++; $display("FAIL drained_flags got empty=%b full=%b want 1/0", IQ_isempty, IQ_isfull); end
    // Pop while empty: no valid pulse.
    tick();
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL pop_empty got en=%b empty=%b want 0/1", en_out, IQ_isempty); end
    Get_Inst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    // Head/tail start at 0; 40 entries wrap the pointers more than twice.
    set_push(1'b1, 32'h0); tick();
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b0) begin errors++; $display("FAIL wrap_first got en=%b empty=%b want 0/0", en_out, IQ_isempty); end
    Get_Inst = 1'b1;
    for (int i = 1; i < 40; i++) begin
      set_push(1'b1, 32'(4*i));
      tick();
      checks++; if (en_out !== 1'b1 || pc_out !== 32'(4*(i-1)) || IQ_isempty !== 1'b0 || IQ_isfull !== 1'b0) begin errors++; $display("FAIL wrap_%0d got en=%b pc=%h empty=%b full=%b want 1/%h/0/0", i, en_out, pc_out, IQ_isempty, IQ_isfull, 32'(4*(i-1))); end
    end
    set_push(1'b0, 32'h0);
    tick();
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h9C || IQ_isempty !== 1'b1) begin errors++; $display("FAIL wrap_last got en=%b pc=%h empty=%b want 1/0000009c/1", en_out, pc_out, IQ_isempty); end
    Get_Inst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    set_push(1'b1, 32'h100); tick();
    set_push(1'b1, 32'h104); Get_Inst = 1'b1; tick();
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h100 || IQ_isempty !== 1'b0) begin errors++; $display("FAIL b2b_first got en=%b pc=%h empty=%b want 1/00000100/0", en_out, pc_out, IQ_isempty); end
    set_push(1'b0, 32'h0); tick();
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h104 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL b2b_second got en=%b pc=%h empty=%b want 1/00000104/1", en_out, pc_out, IQ_isempty); end
    Get_Inst = 1'b0; tick();
    checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL b2b_pulse got en=%b want 0", en_out); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin set_push(1'b1, 32'h300 + 4*i); tick(); end
    set_push(1'b1, 32'h314); Get_Inst = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; set_push(1'b0, 32'h0);
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL clear_state got en=%b empty=%b want 0/1", en_out, IQ_isempty); end
    checks++; if (pc_out !== 32'h104) begin errors++; $display("FAIL clear_hold_pc got %h want 00000104", pc_out); end
    tick();
    checks++; if (en_out !== 1'b0 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL clear_no_retain got en=%b empty=%b want 0/1", en_out, IQ_isempty); end
    Get_Inst = 1'b0;
    set_push(1'b1, 32'h400); tick();
    set_push(1'b0, 32'h0); Get_Inst = 1'b1; tick(); Get_Inst = 1'b0;
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h400) begin errors++; $display("FAIL clear_refill got en=%b pc=%h want 1/00000400", en_out, pc_out); end
    tick();
  endtask

  task automatic test_stall();
    set_push(1'b1, 32'h200); tick();
    set_push(1'b1, 32'h204); tick();
    set_push(1'b0, 32'h0); Get_Inst = 1'b1; tick();
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h200) begin errors++; $display("FAIL stall_pop got en=%b pc=%h want 1/00000200", en_out, pc_out); end
    rdy_in = 1'b0; set_push(1'b1, 32'h208);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (en_out !== 1'b1 || pc_out !== 32'h200 || IQ_isempty !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d got en=%b pc=%h empty=%b want 1/00000200/0", i, en_out, pc_out, IQ_isempty); end
    end
    rdy_in = 1'b1; set_push(1'b0, 32'h0);
    tick();
    checks++; if (en_out !== 1'b1 || pc_out !== 32'h204 || IQ_isempty !== 1'b1) begin errors++; $display("FAIL stall_resume got en=%b pc=%h empty=%b want 1/00000204/1", en_out, pc_out, IQ_isempty); end
    tick();
    checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL stall_no_push got en=%b want 0", en_out); end
    Get_Inst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
